pio_edge_capture: RTL and testbench

PIO_EDGE_CAPTURE -- requirements
Module: pio_edge_capture

---
 rtl/pio_edge_pkg.sv | 20 ++
 rtl/pio_debounce.sv | 59 +++++
 rtl/pio_edge_capture.sv | 157 +++++++++++++++
 tb/tb_pio_edge_capture.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pio_edge_pkg.sv
// -----------------------------------------------------------------------------
// pio_edge_pkg
// Shared definitions for the PIO edge-capture block.
//   ADDR_*       : Avalon-MM word addresses of the register map
//   edge_mode_t  : which input transition is recorded in EDGECAP
// -----------------------------------------------------------------------------
package pio_edge_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_RSVD    = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   typedef enum logic [1:0] {
      RISING  = 2'd0,
      FALLING = 2'd1,
      ANY     = 2'd2
   } edge_mode_t;

endpackage

// File: rtl/pio_debounce.sv
// -----------------------------------------------------------------------------
// pio_debounce
// One-bit debouncer. The output follows the input only after the input has
// disagreed with the output for DEBOUNCE_CYCLES consecutive clocks; any cycle
// of agreement restarts the count.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset (output and count clear to 0)
//   sync_i  : already-synchronized input bit
//   cond_o  : debounced bit
// -----------------------------------------------------------------------------
module pio_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic sync_i,
   output logic cond_o
);

   localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          cond_q;
   logic          cond_d;

   // Count consecutive disagreeing cycles; flip the output on the last one.
   always_comb begin
      cnt_d  = {CW{1'b0}};
      cond_d = cond_q;
      if (sync_i != cond_q) begin
         if (cnt_q == CNT_LAST) begin
            cond_d = sync_i;
            cnt_d  = {CW{1'b0}};
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end else begin
         cnt_d = {CW{1'b0}};
      end
   end

   // Debounce state registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q  <= {CW{1'b0}};
         cond_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         cond_q <= cond_d;
      end
   end

   assign cond_o = cond_q;

endmodule

// File: rtl/pio_edge_capture.sv
// -----------------------------------------------------------------------------
// pio_edge_capture
// Avalon-MM parallel input port with per-bit edge capture and a level IRQ.
// Register map: 0 DATA (RO), 1 reserved, 2 IRQMASK (RW), 3 EDGECAP (RO, W1C).
// Optional feature: define PIO_DEBOUNCE_EN to debounce each input bit
// (window DEBOUNCE_CYCLES) between the synchronizer and the edge logic.
// Ports:
//   clk, reset_n : clock (rising edge), async active-low reset
//   address      : word address
//   chipselect   : slave select, qualifies write_n
//   write_n      : active-low write strobe
//   writedata    : write data
//   in_port      : asynchronous external inputs
//   readdata     : registered read data, 1-cycle latency, upper bits zero
//   irq          : registered |(EDGECAP & IRQMASK)
// -----------------------------------------------------------------------------
module pio_edge_capture
   import pio_edge_pkg::*;
#(
   parameter int unsigned WIDTH           = 4,
   parameter edge_mode_t  EDGE_MODE       = RISING,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync_in_q;
   logic [WIDTH-1:0] cond_in_s;
   logic [WIDTH-1:0] prev_in_q;
   logic [WIDTH-1:0] edge_raw_s;
   logic [WIDTH-1:0] edge_s;
   logic [WIDTH-1:0] clr_s;
   logic [WIDTH-1:0] irqmask_q;
   logic [WIDTH-1:0] irqmask_d;
   logic [WIDTH-1:0] edgecap_q;
   logic [WIDTH-1:0] edgecap_d;
   logic [1:0]       arm_cnt_q;
   logic [1:0]       arm_cnt_d;
   logic             armed_s;
   logic             wr_s;
   logic [31:0]      readdata_d;
   logic [31:0]      readdata_q;
   logic             irq_q;

   // Two-flop synchronizer for the asynchronous pins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q   <= {WIDTH{1'b0}};
         sync_in_q <= {WIDTH{1'b0}};
      end else begin
         sync1_q   <= in_port;
         sync_in_q <= sync1_q;
      end
   end

`ifdef PIO_DEBOUNCE_EN
   for (genvar i = 0; i < WIDTH; i++) begin : g_deb
      pio_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk    (clk),
         .reset_n(reset_n),
         .sync_i (sync_in_q[i]),
         .cond_o (cond_in_s[i])
      );
   end
   logic unused_ok;
   assign unused_ok = ^writedata;
`else
   assign cond_in_s = sync_in_q;
   // Upper writedata bits and the debounce window have no effect in this build.
   logic unused_ok;
   assign unused_ok = ^{writedata, 32'(DEBOUNCE_CYCLES)};
`endif

   // Arming: right after reset prev_in is 0 while inputs may already be high,
   // so edges are ignored until prev_in has caught up with the synchronizer.
   assign armed_s = (arm_cnt_q == 2'd3);
   assign wr_s    = chipselect & ~write_n;

   // Edge detection, register updates and read mux.
   always_comb begin
      case (EDGE_MODE)
         RISING:  edge_raw_s = cond_in_s & ~prev_in_q;
         FALLING: edge_raw_s = ~cond_in_s & prev_in_q;
         ANY:     edge_raw_s = cond_in_s ^ prev_in_q;
         default: edge_raw_s = {WIDTH{1'b0}};
      endcase

      if (armed_s) begin
         edge_s = edge_raw_s;
      end else begin
         edge_s = {WIDTH{1'b0}};
      end

      if (armed_s) begin
         arm_cnt_d = arm_cnt_q;
      end else begin
         arm_cnt_d = arm_cnt_q + 2'd1;
      end

      if (wr_s && (address == ADDR_EDGECAP)) begin
         clr_s = writedata[WIDTH-1:0];
      end else begin
         clr_s = {WIDTH{1'b0}};
      end
      // Set term is applied after the clear so a simultaneous edge wins.
      edgecap_d = (edgecap_q & ~clr_s) | edge_s;

      if (wr_s && (address == ADDR_IRQMASK)) begin
         irqmask_d = writedata[WIDTH-1:0];
      end else begin
         irqmask_d = irqmask_q;
      end

      readdata_d = 32'd0;
      case (address)
         ADDR_DATA:    readdata_d[WIDTH-1:0] = cond_in_s;
         ADDR_RSVD:    readdata_d            = 32'd0;
         ADDR_IRQMASK: readdata_d[WIDTH-1:0] = irqmask_q;
         ADDR_EDGECAP: readdata_d[WIDTH-1:0] = edgecap_q;
         default:      readdata_d            = 32'd0;
      endcase
   end

   // Edge history, arm counter, software registers and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_in_q  <= {WIDTH{1'b0}};
         arm_cnt_q  <= 2'd0;
         irqmask_q  <= {WIDTH{1'b0}};
         edgecap_q  <= {WIDTH{1'b0}};
         readdata_q <= 32'd0;
         irq_q      <= 1'b0;
      end else begin
         prev_in_q  <= cond_in_s;
         arm_cnt_q  <= arm_cnt_d;
         irqmask_q  <= irqmask_d;
         edgecap_q  <= edgecap_d;
         readdata_q <= readdata_d;
         irq_q      <= |(edgecap_q & irqmask_q);
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_pio_edge_capture.sv
// -----------------------------------------------------------------------------
// tb_pio_edge_capture
// Directed bench for pio_edge_capture. Two instances share the bus: dut_r in
// RISING mode and dut_a in ANY mode, each with its own input pins.
// -----------------------------------------------------------------------------
module tb_pio_edge_capture;
   import pio_edge_pkg::*;

`ifdef PIO_DEBOUNCE_EN
   localparam int COND_LAT = 18;  // pin change to cond_in change, in clocks
   localparam int PW       = 20;  // pulse width that survives the debouncer
   localparam int QUIET    = 15;
`else
   localparam int COND_LAT = 2;
   localparam int PW       = 1;
   localparam int QUIET    = 20;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = 32'd0;
   logic [3:0]  in_r = 4'd0;
   logic [3:0]  in_a = 4'd0;
   logic [31:0] readdata_r;
   logic [31:0] readdata_a;
   logic        irq_r;
   logic        irq_a;

   int total_cnt = 0;
   int bad_cnt   = 0;

   always #5 clk = ~clk;

   pio_edge_capture #(.WIDTH(4), .EDGE_MODE(RISING), .DEBOUNCE_CYCLES(16)) dut_r (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_r),
      .readdata(readdata_r), .irq(irq_r)
   );

   pio_edge_capture #(.WIDTH(4), .EDGE_MODE(ANY), .DEBOUNCE_CYCLES(16)) dut_a (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .in_port(in_a),
      .readdata(readdata_a), .irq(irq_a)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got=%h want=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   // Present an address; readdata reflects it after one clock.
   task automatic bus_read(input logic [1:0] a);
      address = a;
      tick();
   endtask

   initial begin
      // Reset state
      #2 reset_n = 1'b0;
      #1;
      chk("rst_rd_r", readdata_r, 32'd0);
      chk("rst_irq_r", {31'd0, irq_r}, 32'd0);
      tick();
      tick();
      reset_n = 1'b1;
      repeat (5) tick();

      // DATA read and pin-to-readdata latency
      address = ADDR_DATA;
      in_r = 4'b1010;
      repeat (COND_LAT) tick();
      chk("data_early", readdata_r, 32'd0);
      tick();
      chk("data_1010", readdata_r, 32'h0000_000A);
      repeat (3) tick();
      bus_read(ADDR_EDGECAP);
      chk("ecap_1010", readdata_r, 32'h0000_000A);
      bus_write(ADDR_EDGECAP, 32'h0000_000F);
      bus_read(ADDR_EDGECAP);
      chk("ecap_clr", readdata_r, 32'd0);
      in_r = 4'b0000;
      repeat (COND_LAT + 4) tick();
      bus_read(ADDR_EDGECAP);
      chk("rise_ign_fall", readdata_r, 32'd0);

      // Reserved address and IRQMASK width
      bus_write(ADDR_RSVD, 32'hDEAD_BEEF);
      bus_read(ADDR_RSVD);
      chk("rsvd_rd", readdata_r, 32'd0);
      bus_write(ADDR_IRQMASK, 32'hFFFF_FFF1);
      bus_read(ADDR_IRQMASK);
      chk("mask_rd", readdata_r, 32'h0000_0001);

      // Rising edge on bit 0 with mask 1, irq lag, W1C clear
      address = ADDR_EDGECAP;
      in_r = 4'b0001;
      repeat (COND_LAT + 1) tick();
      chk("ecap_lag", readdata_r, 32'd0);
      chk("irq_lag", {31'd0, irq_r}, 32'd0);
      tick();
      chk("ecap_b0", readdata_r, 32'h0000_0001);
      chk("irq_set", {31'd0, irq_r}, 32'd1);
      bus_write(ADDR_EDGECAP, 32'h0000_0001);
      tick();
      chk("irq_clr", {31'd0, irq_r}, 32'd0);
      chk("ecap_w1c", readdata_r, 32'd0);

      // Edge on an unmasked bit only: captured, no irq
      in_r = 4'b1001;
      repeat (COND_LAT + 4) tick();
      bus_read(ADDR_EDGECAP);
      chk("ecap_b3", readdata_r, 32'h0000_0008);
      chk("irq_masked", {31'd0, irq_r}, 32'd0);

      // ANY mode: short pulse on bit 2
      in_a = 4'b0100;
      repeat (PW) tick();
      in_a = 4'b0000;
      repeat (COND_LAT + 4) tick();
      bus_read(ADDR_EDGECAP);
      chk("any_pulse", readdata_a, 32'h0000_0004);
      bus_write(ADDR_EDGECAP, 32'h0000_0004);
      bus_read(ADDR_EDGECAP);
      chk("any_clr", readdata_a, 32'd0);

      // Clear written in the same cycle the edge is detected: edge wins
      in_a = 4'b0100;
      repeat (COND_LAT) tick();
      bus_write(ADDR_EDGECAP, 32'h0000_0004);
      bus_read(ADDR_EDGECAP);
      chk("clr_vs_edge", readdata_a, 32'h0000_0004);

      // ANY mode also records a falling edge
      bus_write(ADDR_EDGECAP, 32'h0000_0004);
      bus_read(ADDR_EDGECAP);
      chk("any_clr2", readdata_a, 32'd0);
      in_a = 4'b0000;
      repeat (COND_LAT + 4) tick();
      bus_read(ADDR_EDGECAP);
      chk("any_fall", readdata_a, 32'h0000_0004);

      // Reset mid-operation with everything unmasked
      bus_write(ADDR_IRQMASK, 32'h0000_000F);
      tick();
      chk("irq_r_pre", {31'd0, irq_r}, 32'd1);
      chk("irq_a_pre", {31'd0, irq_a}, 32'd1);
      in_r = 4'hF;
      in_a = 4'hF;
      repeat (4) tick();
      reset_n = 1'b0;
      #1;
      chk("mid_rst_irq_r", {31'd0, irq_r}, 32'd0);
      chk("mid_rst_irq_a", {31'd0, irq_a}, 32'd0);
      chk("mid_rst_rd_r", readdata_r, 32'd0);
      chk("mid_rst_rd_a", readdata_a, 32'd0);
      tick();
      tick();
      reset_n = 1'b1;
      bus_read(ADDR_IRQMASK);
      chk("post_rst_mask", readdata_r, 32'd0);

      // Inputs high at reset release must not register as edges
      bus_write(ADDR_IRQMASK, 32'h0000_000F);
      address = ADDR_EDGECAP;
      for (int i = 0; i < QUIET; i++) begin
         tick();
         chk("quiet_ecap_r", readdata_r, 32'd0);
         chk("quiet_irq_r", {31'd0, irq_r}, 32'd0);
         chk("quiet_ecap_a", readdata_a, 32'd0);
         chk("quiet_irq_a", {31'd0, irq_a}, 32'd0);
      end
      repeat (COND_LAT) tick();
      bus_read(ADDR_DATA);
      chk("data_F", readdata_r, 32'h0000_000F);

`ifdef PIO_DEBOUNCE_EN
      // Bouncing bit 1, then stable high: one debounced rising edge
      in_r = 4'b0000;
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      repeat (5) tick();
      address = ADDR_DATA;
      for (int k = 0; k < 4; k++) begin
         in_r[1] = ~in_r[1];
         repeat (5) tick();
      end
      in_r[1] = 1'b1;
      repeat (COND_LAT) tick();
      chk("deb_data_pre", readdata_r, 32'd0);
      tick();
      chk("deb_data_b1", readdata_r, 32'h0000_0002);
      repeat (3) tick();
      bus_read(ADDR_EDGECAP);
      chk("deb_ecap", readdata_r, 32'h0000_0002);
`endif

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
